// File: rtl/serial_pattern_source.sv
// Serial stimulus source: captures a bit pattern on load and emits it MSB-first,
// one bit per debounced step press, optionally looping back to the first bit.
module serial_pattern_source #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic             loop,
    input  logic             step,
    output logic             w_out,
    output logic             w_valid,
    output logic             adv_pulse,
    output logic [LEN_W-1:0] bit_idx,
    output logic             wrap,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_t             state_reg;
    logic [2:0]         sync_reg;
    logic               step_edge;
    logic [WIDTH-1:0]   shreg_reg;
    logic [WIDTH-1:0]   saved_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               loop_reg;
    logic [LEN_W-1:0]   bit_idx_reg;
    logic               wrap_reg;
    logic               done_reg;
    logic               w_valid_reg;
    logic               w_out_reg;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   last_idx;
    logic [WIDTH-1:0]   aligned;

    // Two synchronizer flops plus a history flop. They reset to 1 so a step
    // held high through reset release is not mistaken for a fresh press.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock or negedge resetn) begin
                    if (!resetn) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= step;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clock or negedge resetn) begin
                    if (!resetn) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign step_edge = sync_reg[1] & ~sync_reg[2];

    // Out-of-range lengths fall back to the full register width.
    always_comb begin
        len_eff = length;
        if (length == '0 || length > WIDTH_L) begin
            len_eff = WIDTH_L;
        end
    end

    // Left-align the used low bits so emission always starts at the MSB.
    assign aligned  = pattern << (WIDTH_L - len_eff);
    assign last_idx = len_reg - 1'b1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            saved_reg   <= '0;
            len_reg     <= '0;
            loop_reg    <= 1'b0;
            bit_idx_reg <= '0;
            wrap_reg    <= 1'b0;
            done_reg    <= 1'b0;
            w_valid_reg <= 1'b0;
            w_out_reg   <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (load) begin
                shreg_reg   <= aligned;
                saved_reg   <= aligned;
                len_reg     <= len_eff;
                loop_reg    <= loop;
                bit_idx_reg <= '0;
                done_reg    <= 1'b0;
                w_valid_reg <= 1'b1;
                w_out_reg   <= aligned[WIDTH-1];
                state_reg   <= ACTIVE;
            end else begin
                case (state_reg)
                    IDLE: begin
                    end
                    ACTIVE: begin
                        if (step_edge) begin
                            if (bit_idx_reg < last_idx) begin
                                shreg_reg   <= shreg_reg << 1;
                                bit_idx_reg <= bit_idx_reg + 1'b1;
                                w_out_reg   <= shreg_reg[WIDTH-2];
                            end else if (loop_reg) begin
                                shreg_reg   <= saved_reg;
                                bit_idx_reg <= '0;
                                wrap_reg    <= 1'b1;
                                w_out_reg   <= saved_reg[WIDTH-1];
                            end else begin
                                done_reg    <= 1'b1;
                                w_valid_reg <= 1'b0;
                                w_out_reg   <= 1'b0;
                                state_reg   <= DONE;
                            end
                        end
                    end
                    DONE: begin
                    end
                    default: begin
                        w_valid_reg <= 1'b0;
                        w_out_reg   <= 1'b0;
                        state_reg   <= IDLE;
                    end
                endcase
            end
        end
    end

    // A load in the same cycle swallows the edge, so no advance is announced.
    assign adv_pulse = step_edge & (state_reg == ACTIVE) & ~load;
    assign w_out     = w_out_reg;
    assign w_valid   = w_valid_reg;
    assign bit_idx   = bit_idx_reg;
    assign wrap      = wrap_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed bench for serial_pattern_source: load/emit, length handling, looping,
// step edge detection, load/edge collision and asynchronous reset.
module tb_serial_pattern_source;

    logic       clock;
    logic       resetn;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] length;
    logic       loop;
    logic       step;
    logic       w_out;
    logic       w_valid;
    logic       adv_pulse;
    logic [3:0] bit_idx;
    logic       wrap;
    logic       done;

    int checks = 0;
    int errors = 0;

    serial_pattern_source #(.WIDTH(8), .LEN_W(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .load      (load),
        .pattern   (pattern),
        .length    (length),
        .loop      (loop),
        .step      (step),
        .w_out     (w_out),
        .w_valid   (w_valid),
        .adv_pulse (adv_pulse),
        .bit_idx   (bit_idx),
        .wrap      (wrap),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_load(input logic [7:0] p, input logic [3:0] len, input logic lp);
        @(posedge clock);
        #1;
        load    = 1'b1;
        pattern = p;
        length  = len;
        loop    = lp;
        @(posedge clock);
        #1;
        load    = 1'b0;
        pattern = 8'h00;
        length  = 4'd0;
        loop    = 1'b0;
    endtask

    // Count adv_pulse samples over a bounded number of cycles.
    task automatic count_adv(input int cycles, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (adv_pulse) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endtask

    // One step press: expects an adv_pulse, checks the bit on offer, then the
    // wrap/done flags one cycle later.
    task automatic press(input string tag, input logic exp_w, input logic [3:0] exp_idx,
                         input logic exp_wrap, input logic exp_done);
        bit found;
        found = 1'b0;
        @(posedge clock);
        #1 step = 1'b1;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clock);
            if (adv_pulse) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s adv_pulse: got none within 8 cycles, expected a pulse", tag);
        end else begin
            checks++;
            if (w_out !== exp_w) begin
                errors++;
                $display("FAIL %s w_out: got %b expected %b", tag, w_out, exp_w);
            end
            checks++;
            if (bit_idx !== exp_idx) begin
                errors++;
                $display("FAIL %s bit_idx: got %0d expected %0d", tag, bit_idx, exp_idx);
            end
        end
        @(posedge clock);
        #1 step = 1'b0;
        @(negedge clock);
        checks++;
        if (wrap !== exp_wrap) begin
            errors++;
            $display("FAIL %s wrap: got %b expected %b", tag, wrap, exp_wrap);
        end
        checks++;
        if (done !== exp_done) begin
            errors++;
            $display("FAIL %s done: got %b expected %b", tag, done, exp_done);
        end
        $display("press %s: w_out=%b bit_idx=%0d wrap=%b done=%b", tag, w_out, bit_idx, wrap, done);
        repeat (4) @(posedge clock);
    endtask

    // Emit n bits; seq holds the expected stream left-aligned (bit 7 first).
    task automatic run_seq(input string tag, input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            press($sformatf("%s[%0d]", tag, i), seq[7-i], 4'(i), 1'b0, (i == n - 1));
        end
        checks++;
        if (w_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s w_valid_after_done: got %b expected 0", tag, w_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({w_out, w_valid, adv_pulse, bit_idx, wrap, done} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {w_out, w_valid, adv_pulse, bit_idx, wrap, done});
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        $display("reset: outputs checked");
    endtask

    task automatic test_full_pattern();
        do_load(8'b1101_0110, 4'd8, 1'b0);
        @(negedge clock);
        checks++;
        if (w_valid !== 1'b1 || bit_idx !== 4'd0 || w_out !== 1'b1) begin
            errors++;
            $display("FAIL load_state: got w_valid=%b bit_idx=%0d w_out=%b expected 1 0 1",
                     w_valid, bit_idx, w_out);
        end
        run_seq("full8", 8'b1101_0110, 8);
    endtask

    task automatic test_lengths();
        int cnt, first;
        do_load(8'b1111_1101, 4'd3, 1'b0);
        run_seq("len3", 8'b1010_0000, 3);
        // Presses in DONE must be ignored.
        @(posedge clock);
        #1 step = 1'b1;
        count_adv(6, cnt, first);
        step = 1'b0;
        repeat (4) @(posedge clock);
        checks++;
        if (cnt !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_step: got adv=%0d done=%b expected 0 1", cnt, done);
        end
        do_load(8'hA5, 4'd0, 1'b0);
        run_seq("len0", 8'hA5, 8);
        do_load(8'h3C, 4'd12, 1'b0);
        run_seq("len12", 8'h3C, 8);
    endtask

    task automatic test_loop();
        do_load(8'b0000_0010, 4'd2, 1'b1);
        press("loop[0]", 1'b1, 4'd0, 1'b0, 1'b0);
        press("loop[1]", 1'b0, 4'd1, 1'b1, 1'b0);
        press("loop[2]", 1'b1, 4'd0, 1'b0, 1'b0);
        press("loop[3]", 1'b0, 4'd1, 1'b1, 1'b0);
        press("loop[4]", 1'b1, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_held_step();
        int cnt, first;
        do_load(8'hC3, 4'd8, 1'b0);
        @(posedge clock);
        #1 step = 1'b1;
        count_adv(20, cnt, first);
        checks++;
        if (cnt !== 1) begin
            errors++;
            $display("FAIL held_count: got %0d pulses expected 1", cnt);
        end
        checks++;
        if (first !== 2) begin
            errors++;
            $display("FAIL held_latency: got pulse at negedge %0d expected 2", first);
        end
        checks++;
        if (bit_idx !== 4'd1 || w_out !== 1'b1) begin
            errors++;
            $display("FAIL held_advance: got bit_idx=%0d w_out=%b expected 1 1", bit_idx, w_out);
        end
        $display("held: pulses=%0d first=%0d bit_idx=%0d", cnt, first, bit_idx);

        // Step held high across reset release, load in the first cycle after.
        @(negedge clock);
        #1 resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn  = 1'b1;
        load    = 1'b1;
        pattern = 8'hC3;
        length  = 4'd8;
        @(posedge clock);
        #1 load = 1'b0;
        count_adv(10, cnt, first);
        checks++;
        if (cnt !== 0 || bit_idx !== 4'd0) begin
            errors++;
            $display("FAIL held_through_reset: got adv=%0d bit_idx=%0d expected 0 0", cnt, bit_idx);
        end
        $display("held through reset: pulses=%0d", cnt);
        step = 1'b0;
        repeat (4) @(posedge clock);
    endtask

    task automatic test_load_collision();
        do_load(8'h5A, 4'd8, 1'b0);
        press("pre[0]", 1'b0, 4'd0, 1'b0, 1'b0);
        press("pre[1]", 1'b1, 4'd1, 1'b0, 1'b0);
        press("pre[2]", 1'b0, 4'd2, 1'b0, 1'b0);
        @(posedge clock);
        #1 step = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        load    = 1'b1;
        pattern = 8'hF0;
        length  = 4'd8;
        loop    = 1'b0;
        @(negedge clock);
        checks++;
        if (adv_pulse !== 1'b0) begin
            errors++;
            $display("FAIL collision_adv: got %b expected 0", adv_pulse);
        end
        @(posedge clock);
        #1 load = 1'b0;
        @(negedge clock);
        checks++;
        if (bit_idx !== 4'd0 || w_out !== 1'b1 || done !== 1'b0 || w_valid !== 1'b1) begin
            errors++;
            $display("FAIL collision_state: got bit_idx=%0d w_out=%b done=%b w_valid=%b expected 0 1 0 1",
                     bit_idx, w_out, done, w_valid);
        end
        $display("collision: bit_idx=%0d w_out=%b", bit_idx, w_out);
        step = 1'b0;
        repeat (4) @(posedge clock);
        press("post[0]", 1'b1, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int cnt, first;
        @(negedge clock);
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({w_out, w_valid, adv_pulse, bit_idx, wrap, done} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 000000000",
                     {w_out, w_valid, adv_pulse, bit_idx, wrap, done});
        end
        #1 resetn = 1'b1;
        @(posedge clock);
        #1 step = 1'b1;
        count_adv(8, cnt, first);
        step = 1'b0;
        checks++;
        if (cnt !== 0 || w_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_step: got adv=%0d w_valid=%b expected 0 0", cnt, w_valid);
        end
        $display("async reset: pulses after=%0d", cnt);
        repeat (4) @(posedge clock);
    endtask

    initial begin
        resetn  = 1'b0;
        load    = 1'b0;
        pattern = 8'h00;
        length  = 4'd0;
        loop    = 1'b0;
        step    = 1'b0;
        test_reset();
        test_full_pattern();
        test_lengths();
        test_loop();
        test_held_step();
        test_load_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_source.md
Name: serial_pattern_source

Overview:
Upstream stimulus stage for the sequence-detector FSM. It captures a bit pattern and emits it serially, one bit per debounced step press, on w_out. Each advance is flagged with a one-cycle adv_pulse, so the detector sees a clean, repeatable input stream and does not rely on hand-toggled switches. The pattern can be emitted once or looped.

Parameters:
WIDTH  8  pattern register width in bits
LEN_W  4  width of length/bit_idx; WIDTH must be <= 2**LEN_W - 1

Ports:
clock     input   1      system clock, rising-edge
resetn    input   1      asynchronous active-low reset
load      input   1      synchronous load strobe; captures pattern/length/loop
pattern   input   WIDTH  bits to emit; the low len_eff bits are used, MSB-first
length    input   LEN_W  number of bits to emit; 0 or >WIDTH means WIDTH
loop      input   1      1 = restart from the first bit after the last bit
step      input   1      raw asynchronous advance request (button level)
w_out     output  1      current serial bit for the detector
w_valid   output  1      w_out holds a live pattern bit
adv_pulse output  1      one-cycle pulse; consumer samples w_out while high
bit_idx   output  LEN_W  index of the bit currently on w_out (0 = first)
wrap      output  1      one-cycle pulse on loop restart
done      output  1      level; the last bit was consumed (non-loop)

Behaviour:
- Clock is `clock`; reset is `resetn`, asynchronous, active-low.
- Reset forces the following values:
  - state IDLE; w_out=0, w_valid=0, adv_pulse=0, bit_idx=0, wrap=0, done=0.
  - Shift and saved-pattern registers = 0.
  - step synchronizer flops = 1, so a step held high through reset release does not advance.
- step path:
  - 2-flop synchronizer s1, s2, then a history flop s3.
  - edge = s2 & ~s3.
  - adv_pulse = edge while in ACTIVE with no load that cycle; otherwise 0.
  - adv_pulse goes high for exactly 1 cycle, 2 clock edges after step rises.
  - A held step produces exactly one advance.
- len_eff = WIDTH if length==0 or length>WIDTH, else length.
- Load action (priority over everything except reset):
  - shreg <= pattern << (WIDTH - len_eff), which left-aligns the used bits.
  - saved copy <= the same value; latch len_eff and loop.
  - bit_idx <= 0; done <= 0; state <= ACTIVE.
  - An edge in the same cycle as load is discarded; no adv_pulse.
- States:
  - IDLE: w_valid=0, w_out=0. Load -> ACTIVE. Step edges are ignored.
  - ACTIVE: w_valid=1, w_out=shreg[WIDTH-1]. On an edge at the clock edge closing the adv_pulse cycle:
    - If bit_idx < len_eff-1: shreg shifts left 1 and bit_idx+1; w_out shows the new bit next cycle.
    - If bit_idx == len_eff-1 and loop=1: shreg <= saved, bit_idx <= 0, wrap pulses for 1 cycle, stay in ACTIVE.
    - If bit_idx == len_eff-1 and loop=0: go to DONE, done <= 1.
  - DONE: w_valid=0, w_out=0, done=1 held. Step edges are ignored. Load -> ACTIVE (clears done).
- A load in any state restarts the pattern from bit 0.
- Reset asserted mid-stream returns everything to reset values immediately, without waiting for a clock.
- Boundary cases:
  - len_eff=1 with loop=1: every edge pulses wrap, and w_out stays at pattern[0].
  - pattern and length are sampled only on load; later changes have no effect.

Test Plan:
1. Reset, then load pattern=8'b1101_0110, length=8, loop=0; 8 step presses -> on each adv_pulse w_out reads 1,1,0,1,0,1,1,0 with bit_idx 0..7. After the 8th press: done=1, w_valid=0.
2. Load pattern=8'bxxxx_x101, length=3, loop=0 -> w_out sequence 1,0,1, then done. length=0 and length=12 each emit all 8 bits.
3. Load pattern=8'b0000_0010, length=2, loop=1; 5 presses -> w_out 1,0,1,0,1. wrap pulses after the 2nd and 4th presses; done stays 0.
4. Hold step high for 20 cycles -> exactly one adv_pulse, 2 cycles after the rise; bit_idx advances by 1. Hold step high across reset release -> no adv_pulse.
5. Mid-stream at bit_idx=3: assert load with pattern=8'hF0, with a step edge in the same cycle -> no adv_pulse; bit_idx=0, w_out=1, done=0.
6. Mid-stream: pulse resetn low between clock edges -> all outputs 0 immediately; subsequent step edges produce no adv_pulse until the next load.
